// File: rtl/cache_pkg.sv
// Shared definitions for the N-way set-associative cache.
// Holds the FSM state codes, a log2 width helper and the default
// geometry used by the top module, its interface and the LRU block.
package cache_pkg;

  // FSM state codes; the numeric values are visible on the state port.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOOKUP     = 3'd1,
    ST_WRITEBACK  = 3'd2,
    ST_FILL_REQ   = 3'd3,
    ST_FILL_WAIT  = 3'd4,
    ST_DONE       = 3'd5
  } state_e;

  // Bits needed to index n items; never returns less than 1.
  function automatic int log2w(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int DEF_WAYS   = 2;
  localparam int DEF_SETS   = 4;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_WAY_W  = log2w(DEF_WAYS);
  localparam int DEF_IDX_W  = log2w(DEF_SETS);

endpackage

// File: rtl/cache_nway_if.sv
// Bus bundle for cache_nway: requester handshake, result outputs and the
// backing-RAM port.  slave = the cache side, master = requester plus RAM.
//   req/we/addr/wdata   request, sampled when req && ready at a clock edge
//   ready/done          idle indicator / one-cycle completion pulse
//   rdata/hit/way       result of the last request, held until next done
//   state               current FSM state code
//   mem_*               synchronous backing RAM, one-cycle read latency
interface cache_nway_if
  import cache_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int WAY_W  = DEF_WAY_W
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              hit;
  logic [WAY_W-1:0]  way;
  logic [2:0]        state;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output ready, done, rdata, hit, way, state, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  ready, done, rdata, hit, way, state, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/cache_lru.sv
// Age-based LRU for one set (purely combinational).
//   valid    per-way valid bits of the set
//   age      per-way ages; always a permutation of 0..WAYS-1
//   acc_way  way being accessed
//   age_next ages after acc_way is touched
//   victim   lowest invalid way, else the way whose age is WAYS-1
module cache_lru
  import cache_pkg::*;
#(
  parameter int WAYS  = DEF_WAYS,
  parameter int WAY_W = log2w(WAYS)
) (
  input  logic [WAYS-1:0]             valid,
  input  logic [WAYS-1:0][WAY_W-1:0]  age,
  input  logic [WAY_W-1:0]            acc_way,
  output logic [WAYS-1:0][WAY_W-1:0]  age_next,
  output logic [WAY_W-1:0]            victim
);

  logic found;

  // NOTE: combinational outputs get a default before any branch so no
  // path leaves them unassigned, which would infer a latch.
  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid[w] && !found) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age[w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
      end
    end
  end

  // Only ways younger than the accessed one age, so the oldest value never
  // exceeds WAYS-1 and the ages stay a permutation.
  always_comb begin
    age_next = age;
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == acc_way) begin
        age_next[w] = '0;
      end else if (age[w] < age[acc_way]) begin
        age_next[w] = age[w] + WAY_W'(1);
      end
    end
  end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative, write-back, write-allocate cache with LRU
// replacement in front of a synchronous backing RAM.
//   clock   rising-edge clock
//   resetn  asynchronous active-low reset; abandons any operation in flight
//   bus     cache_nway_if.slave (request, result and backing-RAM signals)
// Latency accept->done: hit 2, clean miss 4, dirty miss 5 cycles.
module cache_nway
  import cache_pkg::*;
#(
  parameter int WAYS   = DEF_WAYS,
  parameter int SETS   = DEF_SETS,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic        clock,
  input logic        resetn,
  cache_nway_if.slave bus
);

  localparam int WAY_W = log2w(WAYS);
  localparam int IDX_W = log2w(SETS);
  localparam int TAG_W = ADDR_W - IDX_W;

  state_e state_q, state_d;

  // Request captured at accept.
  logic              req_we_q, req_we_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;

  // Result of the access in flight, published on the DONE exit edge.
  logic              acc_hit_q, acc_hit_d;
  logic [WAY_W-1:0]  acc_way_q, acc_way_d;
  logic [DATA_W-1:0] acc_data_q, acc_data_d;

  // Registered outputs.
  logic              done_q, done_d;
  logic              hit_q, hit_d;
  logic [WAY_W-1:0]  way_q, way_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Line storage, one entry per set.
  logic [WAYS-1:0]             valid_q [SETS];
  logic [WAYS-1:0]             valid_d [SETS];
  logic [WAYS-1:0]             dirty_q [SETS];
  logic [WAYS-1:0]             dirty_d [SETS];
  logic [WAYS-1:0][WAY_W-1:0]  age_q   [SETS];
  logic [WAYS-1:0][WAY_W-1:0]  age_d   [SETS];
  logic [WAYS-1:0][TAG_W-1:0]  tag_q   [SETS];
  logic [WAYS-1:0][TAG_W-1:0]  tag_d   [SETS];
  logic [WAYS-1:0][DATA_W-1:0] data_q  [SETS];
  logic [WAYS-1:0][DATA_W-1:0] data_d  [SETS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             lk_hit;
  logic [WAY_W-1:0] lk_way;
  logic [WAY_W-1:0] victim;
  logic [WAYS-1:0][WAY_W-1:0] age_nx;
  logic [DATA_W-1:0] fill_data;

  assign idx = req_addr_q[IDX_W-1:0];
  assign tag = req_addr_q[ADDR_W-1:IDX_W];

  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
    end
  end

  cache_lru #(.WAYS(WAYS), .WAY_W(WAY_W)) u_lru (
    .valid    (valid_q[idx]),
    .age      (age_q[idx]),
    .acc_way  (acc_way_q),
    .age_next (age_nx),
    .victim   (victim)
  );

  // A write miss lays its word over whatever the RAM returned.
  assign fill_data = req_we_q ? req_wdata_q : bus.mem_rdata;

  always_comb begin
    state_d     = state_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    acc_hit_d   = acc_hit_q;
    acc_way_d   = acc_way_q;
    acc_data_d  = acc_data_q;
    done_d      = 1'b0;
    hit_d       = hit_q;
    way_d       = way_q;
    rdata_d     = rdata_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    age_d       = age_q;
    tag_d       = tag_q;
    data_d      = data_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          req_we_d    = bus.we;
          req_addr_d  = bus.addr;
          req_wdata_d = bus.wdata;
          state_d     = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        acc_hit_d = lk_hit;
        if (lk_hit) begin
          acc_way_d = lk_way;
          if (req_we_q) begin
            data_d[idx][lk_way]  = req_wdata_q;
            dirty_d[idx][lk_way] = 1'b1;
            acc_data_d           = req_wdata_q;
          end else begin
            acc_data_d = data_q[idx][lk_way];
          end
          state_d = ST_DONE;
        end else begin
          acc_way_d = victim;
          if (valid_q[idx][victim] && dirty_q[idx][victim]) state_d = ST_WRITEBACK;
          else                                                state_d = ST_FILL_REQ;
        end
      end
      ST_WRITEBACK: state_d = ST_FILL_REQ;
      ST_FILL_REQ:  state_d = ST_FILL_WAIT;
      ST_FILL_WAIT: begin
        valid_d[idx][acc_way_q] = 1'b1;
        dirty_d[idx][acc_way_q] = req_we_q;
        tag_d[idx][acc_way_q]   = tag;
        data_d[idx][acc_way_q]  = fill_data;
        acc_data_d              = fill_data;
        state_d                 = ST_DONE;
      end
      ST_DONE: begin
        done_d     = 1'b1;
        hit_d      = acc_hit_q;
        way_d      = acc_way_q;
        rdata_d    = acc_data_q;
        age_d[idx] = age_nx;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // RAM controls decode straight from the state so mem_we is high for
  // exactly the one WRITEBACK cycle.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state_q)
      ST_WRITEBACK: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {tag_q[idx][acc_way_q], idx};
        bus.mem_wdata = data_q[idx][acc_way_q];
      end
      ST_FILL_REQ: bus.mem_addr = req_addr_q;
      default: ;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      acc_hit_q   <= 1'b0;
      acc_way_q   <= '0;
      acc_data_q  <= '0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      way_q       <= '0;
      rdata_q     <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
      end
    end else begin
      state_q     <= state_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      acc_hit_q   <= acc_hit_d;
      acc_way_q   <= acc_way_d;
      acc_data_q  <= acc_data_d;
      done_q      <= done_d;
      hit_q       <= hit_d;
      way_q       <= way_d;
      rdata_q     <= rdata_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      age_q       <= age_d;
    end
  end

  // NOTE: tag and data arrays carry no reset; a cleared valid bit already
  // makes their contents irrelevant, and leaving them unreset lets them map
  // onto plain storage.
  always_ff @(posedge clock) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign bus.ready = (state_q == ST_IDLE);
  assign bus.done  = done_q;
  assign bus.hit   = hit_q;
  assign bus.way   = way_q;
  assign bus.rdata = rdata_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_cache_nway.sv
// Directed self-checking bench for cache_nway with default geometry
// (2 ways, 4 sets, 5-bit address, 8-bit data).  The backing RAM is modelled
// here with contents RAM[a] = a ^ 0x30 until written.
module tb_cache_nway;
  import cache_pkg::*;

  logic clock;
  logic resetn;

  cache_nway_if bus ();

  cache_nway dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Backing RAM: written words tracked by mask, others follow the preload rule.
  logic [7:0]  ram [32];
  logic [31:0] wr_mask = '0;
  logic [7:0]  mem_rdata_q = '0;
  int          we_cnt = 0;
  int          fill_cnt = 0;
  logic [4:0]  wb_addr = '0;
  logic [7:0]  wb_data = '0;

  function automatic logic [7:0] ram_val(input logic [4:0] a);
    return wr_mask[a] ? ram[a] : ({3'b000, a} ^ 8'h30);
  endfunction

  always @(posedge clock) begin
    mem_rdata_q <= ram_val(bus.mem_addr);
    if (bus.mem_we === 1'b1) begin
      ram[bus.mem_addr]     <= bus.mem_wdata;
      wr_mask[bus.mem_addr] <= 1'b1;
      we_cnt                <= we_cnt + 1;
      wb_addr               <= bus.mem_addr;
      wb_data               <= bus.mem_wdata;
    end
    if (bus.state === 3'd3) fill_cnt <= fill_cnt + 1;
  end

  assign bus.mem_rdata = mem_rdata_q;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request; lat = edges after the accept edge until done is seen
  // (20 means done never came).
  task automatic do_req(input logic w, input logic [4:0] a, input logic [7:0] d,
                        output int lat);
    @(negedge clock);
    bus.req   = 1'b1;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    @(posedge clock);
    #1 bus.req = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clock);
      lat++;
      #1;
      if (bus.done === 1'b1) break;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    int fill0;
    int we0;
    logic rdy_mid;

    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    resetn    = 1'b1;
    #1 resetn = 1'b0;
    #2;
    check("rst_state", 32'(bus.state), 0);
    check("rst_ready", 32'(bus.ready), 1);
    check("rst_done", 32'(bus.done), 0);
    check("rst_hit", 32'(bus.hit), 0);
    check("rst_way", 32'(bus.way), 0);
    check("rst_rdata", 32'(bus.rdata), 0);
    check("rst_mem_we", 32'(bus.mem_we), 0);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    @(negedge clock);
    resetn = 1'b1;

    // Cold miss then hit on 0x05 (set 1).
    do_req(1'b0, 5'h05, 8'h00, lat);
    check("rd05_lat", lat, 4);
    check("rd05_hit", 32'(bus.hit), 0);
    check("rd05_way", 32'(bus.way), 0);
    check("rd05_rdata", 32'(bus.rdata), 32'h35);
    @(posedge clock);
    #1 check("done_one_cycle", 32'(bus.done), 0);
    check("rdata_holds", 32'(bus.rdata), 32'h35);
    do_req(1'b0, 5'h05, 8'h00, lat);
    check("rd05b_lat", lat, 2);
    check("rd05b_hit", 32'(bus.hit), 1);
    check("rd05b_rdata", 32'(bus.rdata), 32'h35);

    // Write hit makes way 0 dirty; 0x09 fills way 1; 0x0D evicts dirty way 0.
    do_req(1'b1, 5'h05, 8'hA5, lat);
    check("wr05_lat", lat, 2);
    check("wr05_hit", 32'(bus.hit), 1);
    check("wr05_rdata", 32'(bus.rdata), 32'hA5);
    do_req(1'b0, 5'h09, 8'h00, lat);
    check("rd09_lat", lat, 4);
    check("rd09_way", 32'(bus.way), 1);
    check("rd09_rdata", 32'(bus.rdata), 32'h39);
    check("no_wb_yet", we_cnt, 0);
    do_req(1'b0, 5'h0D, 8'h00, lat);
    check("rd0d_lat", lat, 5);
    check("rd0d_hit", 32'(bus.hit), 0);
    check("rd0d_way", 32'(bus.way), 0);
    check("rd0d_rdata", 32'(bus.rdata), 32'h3D);
    check("wb_count", we_cnt, 1);
    check("wb_addr", 32'(wb_addr), 32'h05);
    check("wb_data", 32'(wb_data), 32'hA5);
    check("ram05", 32'(ram_val(5'h05)), 32'hA5);
    do_req(1'b0, 5'h05, 8'h00, lat);
    check("rd05c_lat", lat, 4);
    check("rd05c_way", 32'(bus.way), 1);
    check("rd05c_rdata", 32'(bus.rdata), 32'hA5);

    // LRU in set 0: a hit on 0x00 makes 0x04 (way 1) the victim for 0x08.
    do_req(1'b0, 5'h00, 8'h00, lat);
    check("rd00_way", 32'(bus.way), 0);
    do_req(1'b0, 5'h04, 8'h00, lat);
    check("rd04_way", 32'(bus.way), 1);
    check("rd04_rdata", 32'(bus.rdata), 32'h34);
    do_req(1'b0, 5'h00, 8'h00, lat);
    check("rd00b_hit", 32'(bus.hit), 1);
    do_req(1'b0, 5'h08, 8'h00, lat);
    check("rd08_lat", lat, 4);
    check("rd08_hit", 32'(bus.hit), 0);
    check("rd08_way", 32'(bus.way), 1);
    check("rd08_rdata", 32'(bus.rdata), 32'h38);
    check("set0_no_wb", we_cnt, 1);
    do_req(1'b0, 5'h00, 8'h00, lat);
    check("rd00c_hit", 32'(bus.hit), 1);
    check("rd00c_way", 32'(bus.way), 0);
    check("rd00c_rdata", 32'(bus.rdata), 32'h30);

    // Write miss allocates and stays in the cache only.
    do_req(1'b1, 5'h1F, 8'h77, lat);
    check("wr1f_lat", lat, 4);
    check("wr1f_hit", 32'(bus.hit), 0);
    check("wr1f_rdata", 32'(bus.rdata), 32'h77);
    do_req(1'b0, 5'h1F, 8'h00, lat);
    check("rd1f_hit", 32'(bus.hit), 1);
    check("rd1f_rdata", 32'(bus.rdata), 32'h77);
    check("ram1f_untouched", 32'(ram_val(5'h1F)), 32'h2F);
    check("wr1f_no_wb", we_cnt, 1);

    // Reset in the middle of a fill.
    @(negedge clock);
    bus.req  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = 5'h12;
    @(posedge clock);
    #1 bus.req = 1'b0;
    n = 0;
    while (n < 10 && bus.state !== 3'd4) begin
      @(posedge clock);
      n++;
      #1;
    end
    check("reached_fill_wait", 32'(bus.state), 4);
    resetn = 1'b0;
    #1;
    check("midrst_state", 32'(bus.state), 0);
    check("midrst_ready", 32'(bus.ready), 1);
    @(negedge clock);
    resetn = 1'b1;
    do_req(1'b0, 5'h12, 8'h00, lat);
    check("rd12_after_rst_lat", lat, 4);
    check("rd12_after_rst_hit", 32'(bus.hit), 0);
    check("rd12_rdata", 32'(bus.rdata), 32'h22);
    do_req(1'b0, 5'h1F, 8'h00, lat);
    check("rd1f_lost_hit", 32'(bus.hit), 0);
    check("rd1f_lost_rdata", 32'(bus.rdata), 32'h2F);

    // req held high through a clean miss: one service, one fill.
    fill0 = fill_cnt;
    we0   = we_cnt;
    rdy_mid = 1'b1;
    @(negedge clock);
    bus.req  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = 5'h03;
    n = 0;
    while (n < 20) begin
      @(posedge clock);
      n++;
      #1;
      if (n == 2) rdy_mid = bus.ready;
      if (bus.done === 1'b1) break;
    end
    bus.req = 1'b0;
    check("held_edges", n, 5);
    check("held_ready_mid", 32'(rdy_mid), 0);
    check("held_rdata", 32'(bus.rdata), 32'h33);
    check("held_way", 32'(bus.way), 1);
    check("held_fills", fill_cnt - fill0, 1);
    repeat (3) @(posedge clock);
    #1;
    check("held_idle_after", 32'(bus.state), 0);
    check("held_no_more_fill", fill_cnt - fill0, 1);
    check("held_no_wb", we_cnt - we0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_nway.md
CACHE_NWAY -- requirements
Module: cache_nway

Interface
REQ-001 Parameter: WAYS, 2, associativity; power of two, at least 2.
REQ-002 Parameter: SETS, 4, number of sets; power of two.
REQ-003 Parameter: ADDR_W, 5, word address width.
REQ-004 Parameter: DATA_W, 8, word width.
REQ-005 Port: clock  in  1  single clock, rising edge.
REQ-006 Port: resetn  in  1  asynchronous, active-low reset.
REQ-007 Port: req  in  1  request strobe; accepted when req and ready are both 1 at a clock edge.
REQ-008 Port: we  in  1  1 = write, 0 = read; sampled at accept.
REQ-009 Port: addr  in  ADDR_W  word address; sampled at accept.
REQ-010 Port: wdata  in  DATA_W  write data; sampled at accept.
REQ-011 Port: ready  out  1  high only in IDLE.
REQ-012 Port: done  out  1  one-cycle pulse at completion.
REQ-013 Port: rdata  out  DATA_W  read data, or the written word after a write; holds until the next done.
REQ-014 Port: hit  out  1  lookup result of the last request; holds until the next done.
REQ-015 Port: way  out  log2(WAYS)  way hit or filled; holds until the next done.
REQ-016 Port: state  out  3  current FSM state code.
REQ-017 Port: mem_addr  out  ADDR_W, mem_wdata  out  DATA_W, mem_we  out  1  backing-RAM controls.
REQ-018 Port: mem_rdata  in  DATA_W  backing-RAM output; synchronous RAM with one-cycle read latency.

Function
REQ-019 Address split: index = addr[log2(SETS)-1:0]; tag = the remaining upper bits.
REQ-020 Each line holds valid, dirty, tag, one data word and a log2(WAYS)-bit age.
REQ-021 State codes: IDLE=0, LOOKUP=1, WRITEBACK=2, FILL_REQ=3, FILL_WAIT=4, DONE=5.
REQ-022 Transitions:
- IDLE to LOOKUP on accept.
- LOOKUP to DONE on hit.
- LOOKUP to WRITEBACK on a miss with a valid, dirty victim.
- LOOKUP to FILL_REQ otherwise.
- WRITEBACK to FILL_REQ.
- FILL_REQ to FILL_WAIT.
- FILL_WAIT to DONE.
- DONE to IDLE.
REQ-023 Hit: read returns the line data; write replaces the line data and sets dirty (write-back policy).
REQ-024 Victim selection: lowest-index invalid way; if none, the way with age = WAYS-1.
REQ-025 WRITEBACK: mem_we=1 for exactly one cycle, mem_addr = {victim tag, index}, mem_wdata = victim data.
REQ-026 FILL_REQ: mem_addr = request address, mem_we=0.
REQ-027 FILL_WAIT: line installed with valid=1, tag, data = mem_rdata, dirty=0.
REQ-028 Write miss: write-allocate; wdata is merged over the filled data and dirty=1; RAM is not updated until eviction.
REQ-029 LRU update on every completed access: accessed way age becomes 0; ways in the same set with age less than its old age increment by 1; ages in a set always form a permutation of 0..WAYS-1 and never wrap.
REQ-030 Latency from the accept edge to done high: hit 2 cycles, clean miss 4 cycles, dirty miss 5 cycles.
REQ-031 req while ready=0 is ignored and has no side effect.
REQ-032 mem_we=0 in every state except WRITEBACK.

Reset
REQ-033 On resetn=0, asynchronously and immediately:
- state=IDLE, ready=1.
- done=0, hit=0, way=0, rdata=0.
- mem_we=0, mem_addr=0, mem_wdata=0.
- All valid and dirty bits cleared; way w age = w.
REQ-034 Reset during any state, including mid-fill or mid-writeback, abandons the operation; dirty data is lost without writeback.

Structure
REQ-035 Shared package cache_pkg SHALL hold the state codes and the log2 width helper constants.
REQ-036 Sub-module cache_lru SHALL implement age update and victim selection for one set.

Verification (defaults; RAM preloaded with RAM[a]=a XOR 0x30)
REQ-037 After reset, read 0x05 -> done at cycle 4, hit=0, way=0, rdata=0x35; read 0x05 again -> done at cycle 2, hit=1, rdata=0x35.
REQ-038 Write 0xA5 to 0x05 (hit), read 0x09, then read 0x0D -> one mem_we pulse with mem_addr=0x05, mem_wdata=0xA5; done at cycle 5; way=0; RAM[0x05]=0xA5.
REQ-039 Read 0x00, read 0x04, read 0x00, then read 0x08 -> 0x08 replaces way 1 (holding 0x04); no mem_we; a later read of 0x00 has hit=1.
REQ-040 Write 0x77 to 0x1F (miss) -> done at cycle 4, rdata=0x77, dirty set; read 0x1F -> hit=1, rdata=0x77; RAM[0x1F] still 0x2F.
REQ-041 resetn low during FILL_WAIT -> ready=1 and state=0 with no clock edge; the next read of the same address misses.
REQ-042 req held high through a miss -> exactly one request serviced per accept; no extra mem traffic.
